demux_dispatch_1x4: RTL and testbench

- Controller that shares one input stream among four output channels, acting as a registered, flow-controlled 1x4 demux.
- Each beat goes to a channel chosen either by an explicit destination (directed mode) or by a round-robin scheduler that skips busy channels.
- Sits between a single producer and four consumers; each consumer owns a one-entry holding slot.

---
 rtl/demux_dispatch_pkg.sv | 32 +++
 rtl/demux_dispatch_1x4_slot.sv | 44 ++++
 rtl/demux_dispatch_1x4.sv | 110 +++++++++++
 tb/tb_demux_dispatch_1x4.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_dispatch_pkg.sv
// Shared types and helpers for the 1x4 demux dispatcher.
// Optional per-channel beat counters are enabled with DEMUX_DISPATCH_STATS_EN.
package demux_dispatch_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        MODE_DIRECTED = 1'b0,
        MODE_RR       = 1'b1
    } dispatch_mode_t;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // Returns {found, target}: first free channel at or after ptr, wrapping mod 4.
    function automatic logic [SEL_W:0] rr_pick(input ch_sel_t ptr, input logic [NCH-1:0] free);
        logic    found;
        ch_sel_t tgt;
        ch_sel_t idx;
        found = 1'b0;
        tgt   = ptr;
        for (int i = 0; i < NCH; i++) begin
            idx = ptr + ch_sel_t'(i);
            if (!found && free[idx]) begin
                found = 1'b1;
                tgt   = idx;
            end
        end
        return {found, tgt};
    endfunction

endpackage

// File: rtl/demux_dispatch_1x4_slot.sv
// One-entry valid/data holding register for a single output channel.
// A load on the same edge as a drain refills the slot without a bubble.
module demux_slot
    import demux_dispatch_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          drain_i,
    input  logic [DW-1:0] load_data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux_dispatch_1x4.sv
// Registered, flow-controlled 1x4 demux: directed or round-robin target selection.
// Define DEMUX_DISPATCH_STATS_EN to add per-channel saturating beat counters.
module demux_dispatch_1x4
    import demux_dispatch_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [1:0]        in_dest,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*DW-1:0] out_data,
`ifdef DEMUX_DISPATCH_STATS_EN
    output logic [NCH*16-1:0] beat_cnt,
    input  logic              stats_clr,
`endif
    output logic [1:0]        last_sel
);

    dispatch_mode_t   mode_e;
    logic [NCH-1:0]   free;
    logic [SEL_W:0]   rr_res;
    ch_sel_t          target;
    logic             accept;
    ch_sel_t          rr_ptr_q, rr_ptr_d;
    ch_sel_t          last_sel_q, last_sel_d;

    assign mode_e = dispatch_mode_t'(mode);
    assign free   = ~out_valid | out_ready;
    assign rr_res = rr_pick(rr_ptr_q, free);

    // in_ready never depends on in_valid, only on slot state and out_ready.
    always_comb begin
        target   = in_dest;
        in_ready = free[in_dest];
        if (mode_e == MODE_RR) begin
            target   = rr_res[SEL_W-1:0];
            in_ready = rr_res[SEL_W];
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        last_sel_d = last_sel_q;
        if (accept) begin
            last_sel_d = target;
            if (mode_e == MODE_RR) begin
                rr_ptr_d = target + ch_sel_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            last_sel_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            last_sel_q <= last_sel_d;
        end
    end

    assign last_sel = last_sel_q;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
        demux_slot #(.DW(DW)) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (accept && (target == ch_sel_t'(gi))),
            .drain_i     (out_ready[gi]),
            .load_data_i (in_data),
            .valid_o     (out_valid[gi]),
            .data_o      (out_data[gi*DW +: DW])
        );
    end

`ifdef DEMUX_DISPATCH_STATS_EN
    for (genvar gi = 0; gi < NCH; gi++) begin : g_stats
        logic [15:0] cnt_q, cnt_d;

        // Clear takes priority over a same-edge increment.
        always_comb begin
            cnt_d = cnt_q;
            if (stats_clr) begin
                cnt_d = '0;
            end else if (out_valid[gi] && out_ready[gi] && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign beat_cnt[gi*16 +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_demux_dispatch_1x4.sv
// Directed, table-driven bench for demux_dispatch_1x4 plus hand-written reset/stats sequences.
module tb_demux_dispatch_1x4;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_dest;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  last_sel;
`ifdef DEMUX_DISPATCH_STATS_EN
    logic [63:0] beat_cnt;
    logic        stats_clr;
`endif

    int checks = 0;
    int errors = 0;

    demux_dispatch_1x4 #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DEMUX_DISPATCH_STATS_EN
        .beat_cnt  (beat_cnt),
        .stats_clr (stats_clr),
`endif
        .last_sel  (last_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic        vld;
        logic [7:0]  data;
        logic [1:0]  dest;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [31:0] exp_od;
        logic [1:0]  exp_ls;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic m, input logic v, input logic [7:0] d, input logic [1:0] de,
                       input logic [3:0] r, input logic er, input logic [3:0] eov,
                       input logic [31:0] eod, input logic [1:0] els);
        vec_t t;
        t.mode = m; t.vld = v; t.data = d; t.dest = de; t.ordy = r;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_ls = els;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic m, input logic v, input logic [7:0] d,
                         input logic [1:0] de, input logic [3:0] r);
        @(negedge clk);
        mode = m; in_valid = v; in_data = d; in_dest = de; out_ready = r;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; out_ready = '0;
`ifdef DEMUX_DISPATCH_STATS_EN
        stats_clr = 1'b0;
`endif
        // Directed, all ready
        add(0, 1, 8'h11, 2'd3, 4'hF, 1, 4'b1000, 32'h11000000, 2'd3);
        add(0, 1, 8'h22, 2'd0, 4'hF, 1, 4'b0001, 32'h11000022, 2'd0);
        add(0, 1, 8'h33, 2'd2, 4'hF, 1, 4'b0100, 32'h11330022, 2'd2);
        add(0, 1, 8'h44, 2'd1, 4'hF, 1, 4'b0010, 32'h11334422, 2'd1);
        add(0, 0, 8'h00, 2'd0, 4'hF, 1, 4'b0000, 32'h11334422, 2'd1);
        // Directed backpressure on channel 2, then drain+refill on one edge
        add(0, 1, 8'h55, 2'd2, 4'hB, 1, 4'b0100, 32'h11554422, 2'd2);
        add(0, 1, 8'h66, 2'd2, 4'hB, 0, 4'b0100, 32'h11554422, 2'd2);
        add(0, 1, 8'h66, 2'd2, 4'hF, 1, 4'b0100, 32'h11664422, 2'd2);
        add(0, 0, 8'h00, 2'd2, 4'hF, 1, 4'b0000, 32'h11664422, 2'd2);
        // Round-robin rotation; directed beats above must not have moved rr_ptr
        add(1, 1, 8'h01, 2'd3, 4'hF, 1, 4'b0001, 32'h11664401, 2'd0);
        add(1, 1, 8'h02, 2'd3, 4'hF, 1, 4'b0010, 32'h11660201, 2'd1);
        add(1, 1, 8'h03, 2'd3, 4'hF, 1, 4'b0100, 32'h11030201, 2'd2);
        add(1, 1, 8'h04, 2'd3, 4'hF, 1, 4'b1000, 32'h04030201, 2'd3);
        add(1, 1, 8'h05, 2'd3, 4'hF, 1, 4'b0001, 32'h04030205, 2'd0);
        add(1, 1, 8'h06, 2'd3, 4'hF, 1, 4'b0010, 32'h04030605, 2'd1);
        // Round-robin skip with channels 1 and 2 blocked
        add(1, 1, 8'h07, 2'd0, 4'h9, 1, 4'b0110, 32'h04070605, 2'd2);
        add(1, 1, 8'h08, 2'd0, 4'h9, 1, 4'b1110, 32'h08070605, 2'd3);
        add(1, 1, 8'h09, 2'd0, 4'h9, 1, 4'b0111, 32'h08070609, 2'd0);
        add(1, 1, 8'h0A, 2'd0, 4'h9, 1, 4'b1110, 32'h0A070609, 2'd3);
        // All full and blocked: no accept, rr_ptr holds at 1
        add(1, 1, 8'h0B, 2'd0, 4'h0, 1, 4'b1111, 32'h0A07060B, 2'd0);
        add(1, 1, 8'h0C, 2'd0, 4'h0, 0, 4'b1111, 32'h0A07060B, 2'd0);
        add(1, 1, 8'h0C, 2'd0, 4'h0, 0, 4'b1111, 32'h0A07060B, 2'd0);
        add(1, 1, 8'h0C, 2'd0, 4'hF, 1, 4'b0010, 32'h0A070C0B, 2'd1);
        add(1, 0, 8'h00, 2'd0, 4'hF, 1, 4'b0000, 32'h0A070C0B, 2'd1);
        // Mode switching with a held beat
        add(0, 1, 8'h0D, 2'd3, 4'h7, 1, 4'b1000, 32'h0D070C0B, 2'd3);
        add(1, 1, 8'h0E, 2'd0, 4'h7, 1, 4'b1100, 32'h0D0E0C0B, 2'd2);
        add(1, 1, 8'h0F, 2'd0, 4'h7, 1, 4'b1001, 32'h0D0E0C0F, 2'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_out_data",  64'(out_data),  64'h0);
        chk("reset_last_sel",  64'(last_sel),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].vld, vecs[i].data, vecs[i].dest, vecs[i].ordy);
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            chk($sformatf("v%0d_out_data", i),  64'(out_data),  64'(vecs[i].exp_od));
            chk($sformatf("v%0d_last_sel", i),  64'(last_sel),  64'(vecs[i].exp_ls));
            $display("vec %0d mode=%0d vld=%0d data=%h dest=%0d ordy=%b -> rdy=%0d ov=%b od=%h ls=%0d",
                     i, vecs[i].mode, vecs[i].vld, vecs[i].data, vecs[i].dest, vecs[i].ordy,
                     in_ready, out_valid, out_data, last_sel);
        end

        // Reset mid-stream with channels 1 and 2 holding beats
        drive(0, 1, 8'hC1, 2'd1, 4'h9);
        @(posedge clk);
        drive(0, 1, 8'hC2, 2'd2, 4'h9);
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", 64'(out_valid), 64'h6);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'h0);
        chk("async_reset_out_data",  64'(out_data),  64'h0);
        $display("reset mid-stream: ov=%b od=%h", out_valid, out_data);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_last_sel", 64'(last_sel), 64'h0);
        drive(1, 1, 8'hA0, 2'd3, 4'h0);
        chk("first_rr_in_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("first_rr_out_valid", 64'(out_valid), 64'h1);
        chk("first_rr_ch0_data",  64'(out_data[7:0]), 64'hA0);
        chk("first_rr_last_sel",  64'(last_sel), 64'h0);
        $display("first rr beat after reset: ov=%b od=%h ls=%0d", out_valid, out_data, last_sel);

`ifdef DEMUX_DISPATCH_STATS_EN
        // Clear coincides with draining the A0 beat: clear wins
        drive(0, 0, 8'h00, 2'd0, 4'hF);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        chk("stats_clr_vs_inc", beat_cnt, 64'h0);
        drive(0, 1, 8'hB0, 2'd0, 4'h1);
        @(posedge clk);
        drive(0, 1, 8'hB1, 2'd0, 4'h1);
        @(posedge clk);
        drive(0, 1, 8'hB2, 2'd0, 4'h1);
        @(posedge clk);
        drive(0, 0, 8'h00, 2'd0, 4'h1);
        @(posedge clk);
        #1;
        chk("stats_three_drains", beat_cnt, 64'h3);
        drive(0, 1, 8'hB3, 2'd0, 4'h0);
        @(posedge clk);
        #1;
        chk("stats_hold", beat_cnt, 64'h3);
        drive(0, 0, 8'h00, 2'd0, 4'h1);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        chk("stats_clear_4th_drain", beat_cnt, 64'h0);
        chk("stats_4th_drained", 64'(out_valid), 64'h0);
        $display("stats: beat_cnt=%h", beat_cnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
